// File: rtl/fp_div_pkg.sv
// Shared types and constants for the single-precision divider.
// Holds the FSM encoding, field widths and packing helpers for special results.
package fp_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        ROUND,
        DONE
    } state_t;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int SIG_W  = 24;
    localparam int REM_W  = 25;
    localparam int E_W    = 10;
    localparam int QBITS  = 26;

    localparam logic signed [E_W-1:0] EXP_BIAS = 10'sd127;
    localparam logic signed [E_W-1:0] EXP_MAX  = 10'sd255;

    localparam logic [EXP_W-1:0]  EXP_INF   = 8'hFF;
    localparam logic [EXP_W-1:0]  EXP_ZERO  = 8'h00;
    localparam logic [MANT_W-1:0] MANT_ZERO = '0;

    localparam logic [4:0] LAST_ITER = 5'(QBITS - 1);

    function automatic logic [31:0] pack_inf(input logic s);
        return {s, EXP_INF, MANT_ZERO};
    endfunction

    function automatic logic [31:0] pack_zero(input logic s);
        return {s, EXP_ZERO, MANT_ZERO};
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalizes the raw 26-bit quotient, applies round-to-nearest-even and packs
// the result, saturating to infinity on overflow and flushing to zero on underflow.
module fp_round_pack
    import fp_div_pkg::*;
(
    input  logic                  sign,
    input  logic [QBITS-1:0]      quo,
    input  logic                  rem_nz,
    input  logic signed [E_W-1:0] exp_in,
    output logic [31:0]           result
);

    function automatic logic [SIG_W:0] rne(input logic [SIG_W-1:0] kept,
                                           input logic             guard,
                                           input logic             sticky);
        logic inc;
        inc = guard & (sticky | kept[0]);
        return {1'b0, kept} + {{SIG_W{1'b0}}, inc};
    endfunction

    logic [SIG_W-1:0]      kept;
    logic                  guard;
    logic                  sticky;
    logic signed [E_W-1:0] exp_norm;
    logic signed [E_W-1:0] exp_rnd;
    logic [SIG_W:0]        sum;
    logic [MANT_W-1:0]     mant;

    always_comb begin
        // Quotient of two [1,2) significands lies in (0.5,2): at most one left shift.
        if (quo[QBITS-1]) begin
            kept     = quo[QBITS-1:2];
            guard    = quo[1];
            sticky   = quo[0] | rem_nz;
            exp_norm = exp_in;
        end else begin
            kept     = quo[QBITS-2:1];
            guard    = quo[0];
            sticky   = rem_nz;
            exp_norm = exp_in - 10'sd1;
        end

        sum = rne(kept, guard, sticky);

        if (sum[SIG_W]) begin
            mant    = sum[SIG_W-1:1];
            exp_rnd = exp_norm + 10'sd1;
        end else begin
            mant    = sum[MANT_W-1:0];
            exp_rnd = exp_norm;
        end

        if (exp_rnd >= EXP_MAX) begin
            result = pack_inf(sign);
        end else if (exp_rnd <= 10'sd0) begin
            result = pack_zero(sign);
        end else begin
            result = {sign, exp_rnd[EXP_W-1:0], mant};
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 single-precision divider: restoring division, one
// quotient bit per cycle, followed by a single rounding/packing cycle.
module fp_divider
    import fp_div_pkg::*;
#(
    parameter logic [31:0] NAN_OUT = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] fp_a,
    input  logic [31:0] fp_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] fp_out
);

    state_t                state;
    logic [4:0]            iter_cnt;
    logic [QBITS-1:0]      quo;
    logic [REM_W-1:0]      rem;
    logic [SIG_W-1:0]      mb;
    logic signed [E_W-1:0] exp_q;
    logic                  sign_q;

    logic [EXP_W-1:0]      ea;
    logic [EXP_W-1:0]      eb;
    logic                  a_zero, a_inf, a_nan;
    logic                  b_zero, b_inf, b_nan;
    logic                  sign_in;
    logic signed [E_W-1:0] exp_in;
    logic                  special;
    logic [31:0]           special_res;

    logic [SIG_W-1:0]      rem_sub;
    logic                  q_bit;
    logic [REM_W-1:0]      rem_next;
    logic [31:0]           rounded;

    assign ea      = fp_a[30:23];
    assign eb      = fp_b[30:23];
    assign a_zero  = (ea == EXP_ZERO);
    assign b_zero  = (eb == EXP_ZERO);
    assign a_inf   = (ea == EXP_INF) && (fp_a[22:0] == MANT_ZERO);
    assign b_inf   = (eb == EXP_INF) && (fp_b[22:0] == MANT_ZERO);
    assign a_nan   = (ea == EXP_INF) && (fp_a[22:0] != MANT_ZERO);
    assign b_nan   = (eb == EXP_INF) && (fp_b[22:0] != MANT_ZERO);
    assign sign_in = fp_a[31] ^ fp_b[31];
    assign exp_in  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;

    always_comb begin
        special     = 1'b1;
        special_res = NAN_OUT;
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
            special_res = NAN_OUT;
        end else if (a_inf | b_zero) begin
            special_res = pack_inf(sign_in);
        end else if (a_zero | b_inf) begin
            special_res = pack_zero(sign_in);
        end else begin
            special = 1'b0;
        end
    end

    // The partial remainder always stays below 2*mb, so the difference fits 24 bits.
    assign q_bit    = (rem >= {1'b0, mb});
    assign rem_sub  = rem[SIG_W-1:0] - mb;
    assign rem_next = q_bit ? {rem_sub, 1'b0} : {rem[SIG_W-1:0], 1'b0};

    fp_round_pack u_round_pack (
        .sign   (sign_q),
        .quo    (quo),
        .rem_nz (rem != '0),
        .exp_in (exp_q),
        .result (rounded)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            fp_out   <= 32'h0;
            iter_cnt <= '0;
            quo      <= '0;
            rem      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        sign_q   <= sign_in;
                        exp_q    <= exp_in;
                        mb       <= {1'b1, fp_b[22:0]};
                        rem      <= {1'b0, 1'b1, fp_a[22:0]};
                        quo      <= '0;
                        iter_cnt <= '0;
                        if (special) begin
                            fp_out <= special_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= DIV;
                        end
                    end
                end
                DIV: begin
                    quo <= {quo[QBITS-2:0], q_bit};
                    rem <= rem_next;
                    if (iter_cnt == LAST_ITER) begin
                        iter_cnt <= '0;
                        state    <= ROUND;
                    end else begin
                        iter_cnt <= iter_cnt + 5'd1;
                    end
                end
                ROUND: begin
                    fp_out <= rounded;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: the driver queues expected results from an
// exact-integer reference model, an independent monitor checks each done pulse.
module tb_fp_divider;

    localparam logic [31:0] NAN_C = 32'h7FC00000;
    // Edges counted after the accepting edge until done is visible.
    localparam int LAT_SPECIAL = 0;
    localparam int LAT_NORMAL  = 27;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] fp_a;
    logic [31:0] fp_b;
    logic        busy;
    logic        done;
    logic [31:0] fp_out;

    typedef struct {
        logic [31:0] exp_val;
        int          lat;
        longint      acc;
        logic [31:0] a;
        logic [31:0] b;
    } item_t;

    item_t  sb[$];
    longint cyc;
    int     checks;
    int     errors;

    fp_divider #(.NAN_OUT(NAN_C)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .fp_a   (fp_a),
        .fp_b   (fp_b),
        .busy   (busy),
        .done   (done),
        .fp_out (fp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact quotient from 64-bit integer division, then RNE.
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            output bit special);
        logic             s;
        int               ea, eb, e, sh;
        bit               az, ai, an, bz, bi, bn, g, st;
        longint unsigned  num, den, q, r, m;
        logic [63:0]      mv;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bn = (eb == 255) && (b[22:0] != 0);
        special = 1'b1;
        if (an || bn || (az && bz) || (ai && bi)) return NAN_C;
        if (ai || bz) return {s, 8'hFF, 23'h0};
        if (az || bi) return {s, 31'h0};
        special = 1'b0;
        num = longint'({1'b1, a[22:0]}) << 39;
        den = longint'({1'b1, b[22:0]});
        q = num / den;
        r = num % den;
        e = ea - eb + 127;
        if (q >= (64'd1 << 39)) sh = 16;
        else begin
            sh = 15;
            e  = e - 1;
        end
        m  = q >> sh;
        g  = ((q >> (sh - 1)) & 64'd1) != 0;
        st = ((q & ((64'd1 << (sh - 1)) - 1)) != 0) || (r != 0);
        if (g && (st || m[0])) m = m + 1;
        if (m == (64'd1 << 24)) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        mv = m;
        return {s, 8'(e), mv[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        int          k;
        logic [31:0] v;
        k = int'($urandom_range(0, 15));
        v = $urandom;
        if (k == 0) v[30:23] = 8'h00;
        else if (k == 1) begin
            v[30:23] = 8'hFF;
            v[22:0]  = 23'h0;
        end else if (k == 2) begin
            v[30:23] = 8'hFF;
            if (v[22:0] == 23'h0) v[0] = 1'b1;
        end else if (k <= 5) v[30:23] = 8'($urandom_range(1, 254));
        else v[30:23] = 8'($urandom_range(110, 144));
        return v;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_wait busy=%0b required=0 after %0d cycles", busy, n);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        fp_a  = a;
        fp_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat);
        item_t it;
        wait_idle();
        it.exp_val = expv;
        it.lat     = lat;
        it.acc     = cyc + 1;
        it.a       = a;
        it.b       = b;
        sb.push_back(it);
        drive(a, b);
    endtask

    task automatic issue_model(input logic [31:0] a, input logic [31:0] b);
        bit          sp;
        logic [31:0] e;
        e = ref_div(a, b, sp);
        issue(a, b, e, sp ? LAT_SPECIAL : LAT_NORMAL);
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done fp_out=%h required=no done pulse", fp_out);
                end else begin
                    it = sb.pop_front();
                    checks++;
                    if (fp_out !== it.exp_val) begin
                        errors++;
                        $display("FAIL result a=%h b=%h got=%h required=%h",
                                 it.a, it.b, fp_out, it.exp_val);
                    end
                    checks++;
                    if (int'(cyc - it.acc) != it.lat || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL latency a=%h b=%h got=%0d busy=%b required=%0d busy=1",
                                 it.a, it.b, int'(cyc - it.acc), busy, it.lat);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        fp_a   = 32'h0;
        fp_b   = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_busy", {31'h0, busy}, 32'h0);
        check_val("reset_done", {31'h0, done}, 32'h0);
        check_val("reset_fp_out", fp_out, 32'h0);
        rst = 1'b0;

        issue(32'h40C00000, 32'h40000000, 32'h40400000, LAT_NORMAL);
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, LAT_NORMAL);
        issue(32'h3F800000, 32'h00000000, 32'h7F800000, LAT_SPECIAL);
        issue(32'h80000000, 32'h00000000, 32'h7FC00000, LAT_SPECIAL);
        issue(32'hFF800000, 32'h40000000, 32'hFF800000, LAT_SPECIAL);
        issue(32'h7F000000, 32'h3F000000, 32'h7F800000, LAT_NORMAL);
        issue(32'h00800000, 32'h40000000, 32'h00000000, LAT_NORMAL);
        issue(32'h7F800000, 32'hFF800000, 32'h7FC00000, LAT_SPECIAL);
        issue(32'h7F800001, 32'h3F800000, 32'h7FC00000, LAT_SPECIAL);
        issue(32'h00000000, 32'hFF800000, 32'h80000000, LAT_SPECIAL);
        issue(32'h40000000, 32'h7F800000, 32'h00000000, LAT_SPECIAL);
        issue(32'hBF800000, 32'h3F800000, 32'hBF800000, LAT_NORMAL);
        issue(32'h00400000, 32'h3F800000, 32'h00000000, LAT_SPECIAL);

        // A second start during an operation must be ignored.
        issue(32'h40C00000, 32'h40000000, 32'h40400000, LAT_NORMAL);
        repeat (4) @(posedge clk);
        @(negedge clk);
        drive(32'h3F800000, 32'h40400000);

        // Reset partway through an operation aborts it silently.
        wait_idle();
        drive(32'h40490FDB, 32'h402DF854);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("abort_busy", {31'h0, busy}, 32'h0);
        check_val("abort_fp_out", fp_out, 32'h0);
        repeat (30) @(posedge clk);
        check_val("abort_fp_out_hold", fp_out, 32'h0);
        issue(32'h40C00000, 32'h40000000, 32'h40400000, LAT_NORMAL);

        for (int i = 0; i < 150; i++) begin
            issue_model(rand_fp(), rand_fp());
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
